// File: rtl/id_exe_reg.sv
// ID-to-EXE pipeline register: latches decoded fields and control bits, handles
// freeze/flush, and counts inserted bubbles with a saturating counter.
module id_exe_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             imm_in,
  input  logic             s_in,
  input  logic             b_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic [3:0]       status_in,
  input  logic             valid_in,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    val_rn_out,
  output logic [DW-1:0]    val_rm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       exe_cmd_out,
  output logic             imm_out,
  output logic             s_out,
  output logic             b_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             wb_en_out,
  output logic [3:0]       status_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             load_en;
  logic             ctl_en;
  logic             bubble;
  logic [4:0]       ctl_in;
  logic [4:0]       ctl_next;
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_next;

  // Flush overrides freeze, so a flushed edge always loads.
  assign load_en = flush | ~freeze;
  assign ctl_en  = valid_in & ~flush;
  assign bubble  = flush | (~freeze & ~valid_in);

  assign ctl_in = {wb_en_in, mem_w_en_in, mem_r_en_in, b_in, s_in};

  // Side-effect bits only pass from a valid, unflushed slot.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_ctl_gate
      assign ctl_next[gi] = ctl_in[gi] & ctl_en;
    end
  endgenerate

  always_comb begin
    bubble_cnt_next = bubble_cnt_reg;
    if (bubble && (bubble_cnt_reg != CNT_MAX))
      bubble_cnt_next = bubble_cnt_reg + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      exe_cmd_out       <= '0;
      imm_out           <= 1'b0;
      s_out             <= 1'b0;
      b_out             <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      wb_en_out         <= 1'b0;
      status_out        <= '0;
      valid_out         <= 1'b0;
      bubble_cnt_reg    <= '0;
    end else begin
      bubble_cnt_reg <= bubble_cnt_next;
      if (load_en) begin
        // Data fields load even on flush to keep waveforms deterministic.
        pc_out            <= pc_in;
        val_rn_out        <= val_rn_in;
        val_rm_out        <= val_rm_in;
        shift_operand_out <= shift_operand_in;
        signed_imm24_out  <= signed_imm24_in;
        src1_out          <= src1_in;
        src2_out          <= src2_in;
        imm_out           <= imm_in;
        status_out        <= status_in;
        dest_out          <= flush ? 4'd0 : dest_in;
        exe_cmd_out       <= flush ? 4'd0 : exe_cmd_in;
        valid_out         <= valid_in & ~flush;
        wb_en_out         <= ctl_next[4];
        mem_w_en_out      <= ctl_next[3];
        mem_r_en_out      <= ctl_next[2];
        b_out             <= ctl_next[1];
        s_out             <= ctl_next[0];
      end
    end
  end

  assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized and directed bench for id_exe_reg against a field-level reference model;
// a second instance with a 2-bit counter covers saturation.
module tb_id_exe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in, status_in;
  logic        imm_in, s_in, b_in, mem_r_en_in, mem_w_en_in, wb_en_in, valid_in;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out, status_out;
  logic        imm_out, s_out, b_out, mem_r_en_out, mem_w_en_out, wb_en_out, valid_out;
  logic [15:0] bubble_cnt;

  logic [31:0] d2_pc, d2_rn, d2_rm;
  logic [11:0] d2_sh;
  logic [23:0] d2_imm24;
  logic [3:0]  d2_dest, d2_src1, d2_src2, d2_cmd, d2_status;
  logic        d2_imm, d2_s, d2_b, d2_mr, d2_mw, d2_wb, d2_valid;
  logic [1:0]  d2_cnt;

  // Reference model: expected output fields and total bubbles since reset.
  logic [31:0] m_pc, m_rn, m_rm;
  logic [11:0] m_sh;
  logic [23:0] m_imm24;
  logic [3:0]  m_dest, m_src1, m_src2, m_cmd, m_status;
  logic        m_imm, m_s, m_b, m_mr, m_mw, m_wb, m_valid;
  int          m_bub;

  logic [158:0] act_vec, act2_vec, exp_vec;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_exe_reg #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
    .imm_in(imm_in), .s_in(s_in), .b_in(b_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .status_in(status_in), .valid_in(valid_in),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
    .imm_out(imm_out), .s_out(s_out), .b_out(b_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .status_out(status_out),
    .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

  id_exe_reg #(.DW(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
    .imm_in(imm_in), .s_in(s_in), .b_in(b_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .status_in(status_in), .valid_in(valid_in),
    .pc_out(d2_pc), .val_rn_out(d2_rn), .val_rm_out(d2_rm),
    .shift_operand_out(d2_sh), .signed_imm24_out(d2_imm24),
    .dest_out(d2_dest), .src1_out(d2_src1), .src2_out(d2_src2), .exe_cmd_out(d2_cmd),
    .imm_out(d2_imm), .s_out(d2_s), .b_out(d2_b), .mem_r_en_out(d2_mr),
    .mem_w_en_out(d2_mw), .wb_en_out(d2_wb), .status_out(d2_status),
    .valid_out(d2_valid), .bubble_cnt(d2_cnt)
  );

  assign act_vec = {pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm24_out,
                    dest_out, src1_out, src2_out, exe_cmd_out, imm_out, s_out, b_out,
                    mem_r_en_out, mem_w_en_out, wb_en_out, status_out, valid_out};
  assign act2_vec = {d2_pc, d2_rn, d2_rm, d2_sh, d2_imm24, d2_dest, d2_src1, d2_src2,
                     d2_cmd, d2_imm, d2_s, d2_b, d2_mr, d2_mw, d2_wb, d2_status, d2_valid};
  assign exp_vec = {m_pc, m_rn, m_rm, m_sh, m_imm24, m_dest, m_src1, m_src2, m_cmd,
                    m_imm, m_s, m_b, m_mr, m_mw, m_wb, m_status, m_valid};

  function automatic int exp_cnt(input int sat);
    return (m_bub > sat) ? sat : m_bub;
  endfunction

  task automatic model_reset();
    {m_pc, m_rn, m_rm, m_sh, m_imm24, m_dest, m_src1, m_src2, m_cmd} = '0;
    {m_imm, m_s, m_b, m_mr, m_mw, m_wb, m_status, m_valid} = '0;
    m_bub = 0;
  endtask

  // Applies one rising edge's worth of the behavioural rules to the model.
  task automatic model_edge();
    logic side_ok;
    if (rst) begin
      model_reset();
    end else if (flush || !freeze) begin
      m_pc = pc_in;  m_rn = val_rn_in;  m_rm = val_rm_in;  m_sh = shift_operand_in;
      m_imm24 = signed_imm24_in;  m_src1 = src1_in;  m_src2 = src2_in;
      m_imm = imm_in;  m_status = status_in;
      side_ok = valid_in && !flush;
      m_valid = side_ok;
      m_dest  = flush ? 4'd0 : dest_in;
      m_cmd   = flush ? 4'd0 : exe_cmd_in;
      m_wb = wb_en_in & side_ok;     m_mw = mem_w_en_in & side_ok;
      m_mr = mem_r_en_in & side_ok;  m_b  = b_in & side_ok;
      m_s  = s_in & side_ok;
      if (flush || !valid_in) m_bub++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    $display("tx t=%0t rst=%0b flush=%0b freeze=%0b valid_in=%0b pc_out=%h valid_out=%0b cnt=%0d cnt2=%0d",
             $time, rst, flush, freeze, valid_in, pc_out, valid_out, bubble_cnt, d2_cnt);
  endtask

  task automatic rand_inputs();
    pc_in = $urandom;  val_rn_in = $urandom;  val_rm_in = $urandom;
    shift_operand_in = 12'($urandom);  signed_imm24_in = 24'($urandom);
    dest_in = 4'($urandom);  src1_in = 4'($urandom);  src2_in = 4'($urandom);
    exe_cmd_in = 4'($urandom);  status_in = 4'($urandom);
    imm_in = 1'($urandom);  s_in = 1'($urandom);  b_in = 1'($urandom);
    mem_r_en_in = 1'($urandom);  mem_w_en_in = 1'($urandom);  wb_en_in = 1'($urandom);
    valid_in = 1'($urandom);
  endtask

  task automatic test_reset();
    // Get non-zero state into the register first.
    rand_inputs();
    valid_in = 1'b1;  wb_en_in = 1'b1;  pc_in = 32'hDEAD_BEEF;
    freeze = 1'b0;  flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (act_vec !== exp_vec || act_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h expected %h", act_vec, exp_vec);
    end
    n_checks++;
    if (bubble_cnt !== 16'd0 || d2_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bubble_cnt, d2_cnt);
    end
    tick();
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int tbl [5] = '{1, 2, 3, 3, 3};
    rand_inputs();
    freeze = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (d2_cnt !== 2'(tbl[i]) || int'(bubble_cnt) !== exp_cnt(65535)) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %0d/%0d expected %0d/%0d",
                 i, d2_cnt, bubble_cnt, tbl[i], exp_cnt(65535));
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_load_add();
    logic [15:0] cnt_before;
    cnt_before = bubble_cnt;
    rand_inputs();
    valid_in = 1'b1;  exe_cmd_in = 4'b0010;  val_rn_in = 32'h0000_0005;
    val_rm_in = 32'h0000_0003;  shift_operand_in = 12'h003;  s_in = 1'b1;
    wb_en_in = 1'b1;  dest_in = 4'd2;  freeze = 1'b0;  flush = 1'b0;
    tick();
    n_checks++;
    if (act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL load_add_fields: got %h expected %h", act_vec, exp_vec);
    end
    n_checks++;
    if (exe_cmd_out !== 4'b0010 || val_rn_out !== 32'h5 || val_rm_out !== 32'h3 ||
        s_out !== 1'b1 || wb_en_out !== 1'b1 || dest_out !== 4'd2 || valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL load_add_named: got cmd=%h rn=%h rm=%h s=%b wb=%b rd=%0d v=%b expected cmd=2 rn=5 rm=3 s=1 wb=1 rd=2 v=1",
               exe_cmd_out, val_rn_out, val_rm_out, s_out, wb_en_out, dest_out, valid_out);
    end
    n_checks++;
    if (bubble_cnt !== cnt_before) begin
      n_fail++;
      $display("FAIL load_add_cnt: got %0d expected %0d", bubble_cnt, cnt_before);
    end
  endtask

  task automatic test_freeze();
    logic [15:0] cnt_before;
    logic [3:0]  st_before;
    rand_inputs();
    valid_in = 1'b1;  pc_in = 32'h0000_0010;  freeze = 1'b0;  flush = 1'b0;
    tick();
    cnt_before = bubble_cnt;
    st_before  = status_out;
    pc_in = 32'h0000_0014;  freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      status_in = ~status_in;
      valid_in  = 1'($urandom);
      tick();
      n_checks++;
      if (pc_out !== 32'h0000_0010 || bubble_cnt !== cnt_before || status_out !== st_before ||
          act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: got pc=%h cnt=%0d st=%h expected pc=00000010 cnt=%0d st=%h",
                 i, pc_out, bubble_cnt, status_out, cnt_before, st_before);
      end
    end
    freeze = 1'b0;  valid_in = 1'b1;
    tick();
    n_checks++;
    if (pc_out !== 32'h0000_0014 || act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL freeze_release: got pc=%h expected 00000014", pc_out);
    end
  endtask

  task automatic test_flush_freeze();
    logic [15:0] cnt_before;
    cnt_before = bubble_cnt;
    rand_inputs();
    freeze = 1'b1;  flush = 1'b1;  wb_en_in = 1'b1;  mem_w_en_in = 1'b1;  valid_in = 1'b1;
    exe_cmd_in = 4'hA;  dest_in = 4'h7;
    tick();
    n_checks++;
    if (valid_out !== 1'b0 || wb_en_out !== 1'b0 || mem_w_en_out !== 1'b0 ||
        exe_cmd_out !== 4'd0 || dest_out !== 4'd0 || act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL flush_freeze: got v=%b wb=%b mw=%b cmd=%h rd=%h expected all 0",
               valid_out, wb_en_out, mem_w_en_out, exe_cmd_out, dest_out);
    end
    n_checks++;
    if (bubble_cnt !== cnt_before + 16'd1) begin
      n_fail++;
      $display("FAIL flush_freeze_cnt: got %0d expected %0d", bubble_cnt, cnt_before + 16'd1);
    end
    flush = 1'b0;  freeze = 1'b0;
  endtask

  task automatic test_invalid_gating();
    logic [15:0] cnt_before;
    cnt_before = bubble_cnt;
    rand_inputs();
    valid_in = 1'b0;  mem_r_en_in = 1'b1;  wb_en_in = 1'b1;  b_in = 1'b1;
    s_in = 1'b1;  mem_w_en_in = 1'b1;  freeze = 1'b0;  flush = 1'b0;
    tick();
    n_checks++;
    if (mem_r_en_out !== 1'b0 || wb_en_out !== 1'b0 || b_out !== 1'b0 ||
        s_out !== 1'b0 || mem_w_en_out !== 1'b0 || valid_out !== 1'b0 || act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL invalid_gating: got mr=%b wb=%b b=%b s=%b mw=%b v=%b expected all 0",
               mem_r_en_out, wb_en_out, b_out, s_out, mem_w_en_out, valid_out);
    end
    n_checks++;
    if (bubble_cnt !== cnt_before + 16'd1) begin
      n_fail++;
      $display("FAIL invalid_cnt: got %0d expected %0d", bubble_cnt, cnt_before + 16'd1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      valid_in = ($urandom_range(3, 0) != 0);
      flush    = ($urandom_range(7, 0) == 0);
      freeze   = ($urandom_range(3, 0) == 0);
      tick();
      n_checks++;
      if (act_vec !== exp_vec || act2_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_fields[%0d]: got %h expected %h", i, act_vec, exp_vec);
      end
      n_checks++;
      if (int'(bubble_cnt) !== exp_cnt(65535) || int'(d2_cnt) !== exp_cnt(3)) begin
        n_fail++;
        $display("FAIL random_cnt[%0d]: got %0d/%0d expected %0d/%0d",
                 i, bubble_cnt, d2_cnt, exp_cnt(65535), exp_cnt(3));
      end
    end
    flush = 1'b0;  freeze = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  freeze = 1'b0;  flush = 1'b0;
    rand_inputs();
    model_reset();
    #12;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_saturation();
    test_load_add();
    test_freeze();
    test_flush_freeze();
    test_invalid_gating();
    test_random();
    test_reset();
    test_load_add();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
